trap_controller: RTL

- Sequences trap entry and trap return for the core, driven by the commit stage's exception and xRET outputs plus an external interrupt request.
- Captures the faulting PC and cause, and writes mepc and mcause through a dedicated CSR write port.
- Stalls the pipeline, then issues a PC redirect to fetch with a ready/valid handshake, and flushes younger instructions.
- Sits between the commit stage, the CSR file and the fetch stage.

---
 rtl/trap_controller.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/trap_controller.sv
// Trap entry/return sequencer: captures PC and cause, writes mepc/mcause, redirects fetch, then flushes.
// Optional TRAP_VECTORED_EN: interrupts jump to base + 4*cause when mtvec[1:0] == 2'b01.
module trap_controller #(
  parameter int          XLEN         = 32,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            commit_valid,
  input  logic            exception_pending,
  input  logic [XLEN-1:0] pc_exc,
  input  logic [XLEN-1:0] cause,
  input  logic            mret,
  input  logic            sret,
  input  logic            uret,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [XLEN-1:0] uepc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            mstatus_mie,
  input  logic            irq_pending,
  input  logic [4:0]      irq_cause,
  output logic            kill_commit,
  output logic            stall,
  output logic            flush,
  output logic            csr_trap_we,
  output logic [11:0]     csr_trap_addr,
  output logic [XLEN-1:0] csr_trap_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            trap_enter,
  output logic [1:0]      trap_return,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    REDIRECT,
    FLUSH
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] epc_q, cause_q, tgt_q;
  logic [1:0]      ret_q;
  logic            first_redirect_q;
  logic [3:0]      flush_cnt_q;

  logic            any_ret, irq_take;
  logic            sel_exc, sel_ret, sel_irq;
  logic [1:0]      ret_code;
  logic [XLEN-1:0] ret_epc, trap_base, irq_tgt, irq_cause_full;

  assign any_ret  = mret | sret | uret;
  assign irq_take = irq_pending & mstatus_mie;

  // Fixed priority: exception, then xRET, then interrupt.
  assign sel_exc = commit_valid & exception_pending;
  assign sel_ret = commit_valid & ~exception_pending & any_ret;
  assign sel_irq = commit_valid & ~exception_pending & ~any_ret & irq_take;

  always_comb begin
    ret_code = 2'b00;
    ret_epc  = uepc;
    if (mret) begin
      ret_code = 2'b01;
      ret_epc  = mepc;
    end else if (sret) begin
      ret_code = 2'b10;
      ret_epc  = sepc;
    end else if (uret) begin
      ret_code = 2'b11;
      ret_epc  = uepc;
    end
  end

  assign trap_base      = {mtvec[XLEN-1:2], 2'b00};
  assign irq_cause_full = {1'b1, {(XLEN-6){1'b0}}, irq_cause};

`ifdef TRAP_VECTORED_EN
  assign irq_tgt = (mtvec[1:0] == 2'b01) ?
                   trap_base + {{(XLEN-7){1'b0}}, irq_cause, 2'b00} : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign irq_tgt           = trap_base;
`endif

  assign kill_commit = (state_q == IDLE) & commit_valid &
                       (exception_pending | (irq_take & ~any_ret));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sel_exc || sel_irq) begin
          state_d = W_EPC;
        end else if (sel_ret) begin
          state_d = REDIRECT;
        end
      end
      W_EPC:    state_d = W_CAUSE;
      W_CAUSE:  state_d = REDIRECT;
      REDIRECT: if (redirect_ready) state_d = FLUSH;
      FLUSH:    if (flush_cnt_q == 4'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    csr_trap_we    = 1'b0;
    csr_trap_addr  = 12'h000;
    csr_trap_wdata = '0;
    trap_enter     = 1'b0;
    trap_return    = 2'b00;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    flush          = 1'b0;
    case (state_q)
      W_EPC: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = MEPC_ADDR;
        csr_trap_wdata = epc_q;
      end
      W_CAUSE: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = MCAUSE_ADDR;
        csr_trap_wdata = cause_q;
        trap_enter     = 1'b1;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt_q;
        trap_return    = first_redirect_q ? ret_q : 2'b00;
      end
      FLUSH:   flush = 1'b1;
      default: ;
    endcase
  end

  assign stall = (state_q != IDLE);
  assign busy  = stall;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q          <= IDLE;
      epc_q            <= '0;
      cause_q          <= '0;
      tgt_q            <= '0;
      ret_q            <= 2'b00;
      first_redirect_q <= 1'b0;
      flush_cnt_q      <= 4'd0;
    end else begin
      state_q          <= state_d;
      first_redirect_q <= (state_d == REDIRECT) && (state_q != REDIRECT);
      if (state_q == IDLE && (sel_exc || sel_ret || sel_irq)) begin
        epc_q   <= pc_exc;
        cause_q <= sel_exc ? cause : irq_cause_full;
        tgt_q   <= sel_ret ? ret_epc : (sel_exc ? trap_base : irq_tgt);
        ret_q   <= sel_ret ? ret_code : 2'b00;
      end
      // Counter is loaded on the handshake so FLUSH lasts exactly FLUSH_CYCLES cycles.
      if (state_q == REDIRECT && redirect_ready) begin
        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
      end else if (state_q == FLUSH && flush_cnt_q != 4'd0) begin
        flush_cnt_q <= flush_cnt_q - 4'd1;
      end
    end
  end

endmodule
